// File: rtl/sd_img_pkg.sv
// sd_img_pkg: shared image geometry constants and the loader state encoding.
// Rev 1.0
`default_nettype none

package sd_img_pkg;

  localparam int IMG_W_DEF    = 640;
  localparam int IMG_H_DEF    = 480;
  localparam int SECTOR_BYTES = 512;
  localparam int NUM_SECTORS  = IMG_W_DEF * IMG_H_DEF / SECTOR_BYTES;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WAIT_READY = 3'd1,
    ISSUE      = 3'd2,
    RECEIVE    = 3'd3,
    NEXT       = 3'd4,
    DRAIN      = 3'd5,
    DONE       = 3'd6
  } state_e;

endpackage

`default_nettype wire

// File: rtl/sd_pixel_streamer_byte_fifo.sv
// byte_fifo: first-word-fall-through byte FIFO, power-of-two depth, async active-low reset.
// Rev 1.0
`default_nettype none

module byte_fifo #(
  parameter int DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push_i,
  input  logic [7:0] din_i,
  input  logic       pop_i,
  output logic [7:0] dout_o,
  output logic       full_o,
  output logic       empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]  mem_q [DEPTH];
  logic [AW:0] wr_ptr_q;
  logic [AW:0] rd_ptr_q;
  logic        push_ok;
  logic        pop_ok;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);

  assign dout_o = empty_o ? 8'h00 : mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
  end

endmodule

`default_nettype wire

// File: rtl/sd_pixel_streamer.sv
// sd_pixel_streamer: sequences SD single-block reads for one image and emits a tagged pixel stream.
// Rev 1.0 -- define SDHC_BLOCK_ADDR_EN for block addressing (SDHC/SDXC), else byte addressing.
`default_nettype none

module sd_pixel_streamer
  import sd_img_pkg::*;
#(
  parameter int START_SECTOR = 0,
  parameter int IMG_W        = IMG_W_DEF,
  parameter int IMG_H        = IMG_H_DEF,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        sd_ready,
  input  logic        sd_byte_available,
  input  logic [7:0]  sd_dout,
  output logic        sd_rd,
  output logic [31:0] sd_address,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic [7:0]  pix_data,
  output logic [9:0]  pix_x,
  output logic [8:0]  pix_y,
  output logic [18:0] pix_addr,
  output logic        pix_last,
  output logic        busy,
  output logic        done,
  output logic        overflow
);

  localparam int         NUM_SECT  = IMG_W * IMG_H / SECTOR_BYTES;
  localparam logic [9:0] LAST_SECT = 10'(NUM_SECT);
  localparam logic [9:0] X_MAX     = 10'(IMG_W - 1);
  localparam logic [8:0] Y_MAX     = 9'(IMG_H - 1);

  state_e      state_q, state_d;
  logic [9:0]  sector_q, sector_d;
  logic [8:0]  byte_q, byte_d;
  logic        sd_rd_q, sd_rd_d;
  logic [31:0] addr_q, addr_d;
  logic        ovf_q, ovf_d;
  logic [9:0]  x_q, x_d;
  logic [8:0]  y_q, y_d;
  logic [18:0] paddr_q, paddr_d;

  logic        launch;
  logic        byte_ok;
  logic        xfer;
  logic        drop;
  logic        fifo_full;
  logic        fifo_empty;
  logic [31:0] blk_addr;
  logic [31:0] sd_addr_next;

  assign blk_addr = 32'(START_SECTOR) + {22'd0, sector_q};
`ifdef SDHC_BLOCK_ADDR_EN
  assign sd_addr_next = blk_addr;
`else
  assign sd_addr_next = blk_addr << 9;
`endif

  // The SD controller cannot be stalled, so bytes are only taken while a block is in flight.
  assign byte_ok = sd_byte_available && ((state_q == ISSUE) || (state_q == RECEIVE));
  assign xfer    = !fifo_empty && pix_ready;
  assign drop    = byte_ok && fifo_full && !xfer;

  byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset_n),
    .push_i  (byte_ok),
    .din_i   (sd_dout),
    .pop_i   (pix_ready),
    .dout_o  (pix_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    state_d  = state_q;
    sector_d = sector_q;
    byte_d   = byte_q;
    sd_rd_d  = sd_rd_q;
    addr_d   = addr_q;
    ovf_d    = ovf_q;
    launch   = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          launch   = 1'b1;
          sector_d = '0;
          byte_d   = '0;
          ovf_d    = 1'b0;
          state_d  = WAIT_READY;
        end
      end
      WAIT_READY: begin
        if (sd_ready) begin
          addr_d  = sd_addr_next;
          sd_rd_d = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (sd_byte_available) begin
          sd_rd_d = 1'b0;
          byte_d  = byte_q + 9'd1;
          state_d = RECEIVE;
        end
      end
      RECEIVE: begin
        if (sd_byte_available) begin
          byte_d = byte_q + 9'd1;
          if (byte_q == 9'd511) state_d = NEXT;
        end
      end
      NEXT: begin
        sector_d = sector_q + 10'd1;
        state_d  = (sector_d == LAST_SECT) ? DRAIN : WAIT_READY;
      end
      DRAIN: begin
        // Dropped bytes shorten the image, so an empty FIFO is the only safe end marker.
        if (fifo_empty) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
    if (drop) ovf_d = 1'b1;
  end

  always_comb begin
    x_d     = x_q;
    y_d     = y_q;
    paddr_d = paddr_q;
    if (launch) begin
      x_d     = '0;
      y_d     = '0;
      paddr_d = '0;
    end else if (xfer) begin
      paddr_d = paddr_q + 19'd1;
      if (x_q == X_MAX) begin
        x_d = '0;
        y_d = (y_q == Y_MAX) ? 9'd0 : y_q + 9'd1;
      end else begin
        x_d = x_q + 10'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      sector_q <= '0;
      byte_q   <= '0;
      sd_rd_q  <= 1'b0;
      addr_q   <= '0;
      ovf_q    <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      paddr_q  <= '0;
    end else begin
      state_q  <= state_d;
      sector_q <= sector_d;
      byte_q   <= byte_d;
      sd_rd_q  <= sd_rd_d;
      addr_q   <= addr_d;
      ovf_q    <= ovf_d;
      x_q      <= x_d;
      y_q      <= y_d;
      paddr_q  <= paddr_d;
    end
  end

  assign sd_rd      = sd_rd_q;
  assign sd_address = addr_q;
  assign pix_valid  = !fifo_empty;
  assign pix_x      = x_q;
  assign pix_y      = y_q;
  assign pix_addr   = paddr_q;
  assign pix_last   = pix_valid && (x_q == X_MAX) && (y_q == Y_MAX);
  assign busy       = (state_q != IDLE) && (state_q != DONE);
  assign done       = (state_q == DONE);
  assign overflow   = ovf_q;

endmodule

`default_nettype wire
